// File: rtl/dma_priority_arbiter_if.sv
// Bus-side signal bundle for the DMA channel arbiter.
// The master modport is the arbiter's view; slave is the CPU/peripheral/timing-engine side.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic [NUM_CH-1:0] MASK;
    logic [NUM_CH-1:0] SW_REQ;
    logic              ROT_PRI;
    logic              DREQ_SENSE_LOW;
    logic              DACK_SENSE_HIGH;
    logic              XFER_DONE;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [CH_W-1:0]   ACTIVE_CH;
    logic              GRANT_VALID;
    logic [NUM_CH-1:0] REQ_STATUS;

    modport master (
        input  DREQ, HLDA, MASK, SW_REQ, ROT_PRI, DREQ_SENSE_LOW, DACK_SENSE_HIGH, XFER_DONE,
        output HRQ, DACK, ACTIVE_CH, GRANT_VALID, REQ_STATUS
    );

    modport slave (
        output DREQ, HLDA, MASK, SW_REQ, ROT_PRI, DREQ_SENSE_LOW, DACK_SENSE_HIGH, XFER_DONE,
        input  HRQ, DACK, ACTIVE_CH, GRANT_VALID, REQ_STATUS
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA channel arbiter: DREQ sync, fixed/rotating priority, HRQ/HLDA handshake, DACK.
// Optional DMA_ARB_DEMAND_MODE_EN ends a grant when the active channel withdraws its request.
module dma_priority_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                     CLK,
    input logic                     RESET_N,
    dma_priority_arbiter_if.master  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [SYNC_STAGES*NUM_CH-1:0] sync_chain;
    logic [NUM_CH-1:0]             dreq_sync;
    logic [NUM_CH-1:0]             eff_req;
    logic [NUM_CH-1:0]             sw_req;
    logic [NUM_CH-1:0]             sw_clr;
    logic [NUM_CH-1:0]             dack_oh;
    logic [NUM_CH-1:0]             req_status;
    logic [1:0]                    state;
    logic                          hrq;
    logic                          grant_valid;
    logic                          any_req;
    logic                          demand_drop;
    logic [CH_W-1:0]               active_ch;
    logic [CH_W-1:0]               pri_ptr;
    logic [CH_W-1:0]               next_ptr;
    logic [CH_W-1:0]               winner;
    logic [CH_W-1:0]               search_base;
    logic [CH_W:0]                 search_idx;
    logic                          found;

    assign dreq_sync = sync_chain[SYNC_STAGES*NUM_CH-1 -: NUM_CH] ^ {NUM_CH{bus.DREQ_SENSE_LOW}};
    assign eff_req   = (dreq_sync & ~bus.MASK) | sw_req;
    assign any_req   = |eff_req;
    assign next_ptr  = (active_ch == CH_W'(NUM_CH-1)) ? '0 : active_ch + 1'b1;
    assign sw_clr    = (bus.XFER_DONE && grant_valid) ? (NUM_CH'(1) << active_ch) : '0;

`ifdef DMA_ARB_DEMAND_MODE_EN
    assign demand_drop = ~eff_req[active_ch];
`else
    assign demand_drop = 1'b0;
`endif

    // Scan channels starting at the base (0 in fixed mode), wrapping modulo NUM_CH; first hit wins.
    always_comb begin
        search_base = bus.ROT_PRI ? pri_ptr : '0;
        search_idx  = '0;
        winner      = '0;
        found       = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
            search_idx = {1'b0, search_base} + (CH_W+1)'(off);
            if (search_idx >= NUM_CH_W) begin
                search_idx = search_idx - NUM_CH_W;
            end
            if (!found && eff_req[search_idx[CH_W-1:0]]) begin
                winner = search_idx[CH_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync_chain  <= '0;
            sw_req      <= '0;
            req_status  <= '0;
            state       <= ST_IDLE;
            hrq         <= 1'b0;
            grant_valid <= 1'b0;
            dack_oh     <= '0;
            active_ch   <= '0;
            pri_ptr     <= '0;
        end else begin
            sync_chain <= {sync_chain[(SYNC_STAGES-1)*NUM_CH-1:0], bus.DREQ};
            sw_req     <= (sw_req & ~sw_clr) | bus.SW_REQ;
            req_status <= eff_req;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_REQ;
                        hrq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.HLDA) begin
                        if (any_req) begin
                            state       <= ST_GRANT;
                            active_ch   <= winner;
                            dack_oh     <= NUM_CH'(1) << winner;
                            grant_valid <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            hrq   <= 1'b0;
                        end
                    end
                end
                // Aborts and demand withdrawals leave the priority pointer untouched.
                ST_GRANT: begin
                    if (!bus.HLDA || bus.XFER_DONE || demand_drop) begin
                        state       <= ST_RELEASE;
                        hrq         <= 1'b0;
                        grant_valid <= 1'b0;
                        dack_oh     <= '0;
                        if (bus.HLDA && bus.XFER_DONE && bus.ROT_PRI) begin
                            pri_ptr <= next_ptr;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!bus.HLDA) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.HRQ         = hrq;
    assign bus.GRANT_VALID = grant_valid;
    assign bus.ACTIVE_CH   = active_ch;
    assign bus.REQ_STATUS  = req_status;
    assign bus.DACK        = bus.DACK_SENSE_HIGH ? dack_oh : ~dack_oh;
endmodule
